// File: rtl/and_gate_project_pkg.sv
// Shared constants for the switch-to-LED path: default debounce window and
// the counter width rule used by every debounce filter.
package and_gate_project_pkg;

    // 10 ms at 25 MHz.
    localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;

    // Counter must hold DEBOUNCE_LIMIT-1; the extra bit keeps the width
    // non-zero when the limit is 1.
    function automatic int debounce_cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/and_gate_project_debounce_filter.sv
// One switch channel: two-flop synchronizer followed by a counter-based
// debounce filter that accepts a new level after DEBOUNCE_LIMIT stable cycles.
module debounce_filter
    import and_gate_project_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Bouncy,
    output logic o_Debounced
);

    localparam int CNT_W = debounce_cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = i_Bouncy;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        // Any cycle where the synchronized level matches the accepted one
        // breaks the run, so short glitches never accumulate.
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q >= LIMIT_M1) begin
            state_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Debounced = state_q;

endmodule

// File: rtl/and_gate_project.sv
// Switch-to-LED demo top: two independent debounced switch channels feeding a
// registered AND that drives the LED pin.
module and_gate_project
    import and_gate_project_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_LED_1
);

    logic debounced_1;
    logic debounced_2;
    logic led_q, led_d;

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_filter_1 (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Bouncy   (i_Switch_1),
        .o_Debounced(debounced_1)
    );

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_filter_2 (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Bouncy   (i_Switch_2),
        .o_Debounced(debounced_2)
    );

    always_comb begin
        led_d = debounced_1 & debounced_2;
    end

    // Driving the pin straight from a flop keeps the LED free of glitches.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign o_LED_1 = led_q;

endmodule

// File: tb/tb_and_gate_project.sv
// Bench for and_gate_project with DEBOUNCE_LIMIT = 4: directed scenarios plus
// randomized switch activity, checked every cycle against a history-window model.
module tb_and_gate_project;

    localparam int LIMIT = 4;
    localparam int LAT   = LIMIT + 3;

    logic clk;
    logic rst;
    logic sw1;
    logic sw2;
    logic led;

    int n_checks = 0;
    int n_errors = 0;

    and_gate_project #(
        .DEBOUNCE_LIMIT(LIMIT)
    ) dut (
        .i_Clk     (clk),
        .i_Reset   (rst),
        .i_Switch_1(sw1),
        .i_Switch_2(sw2),
        .o_LED_1   (led)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Each channel keeps the raw level seen at every edge. A level two edges
    // old is what the synchronizer presents; the debounced value flips once
    // LIMIT consecutive presented levels disagree with it.
    int hist1[$];
    int hist2[$];
    int deb1;
    int deb2;
    int model_led;

    function automatic bit window_flips(input int h[$], input int deb);
        if (h.size() < LIMIT + 2) return 1'b0;
        for (int j = 0; j < LIMIT; j++) begin
            if (h[h.size() - 3 - j] == deb) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        hist1.delete();
        hist2.delete();
        for (int i = 0; i < LIMIT + 2; i++) begin
            hist1.push_back(0);
            hist2.push_back(0);
        end
        deb1      = 0;
        deb2      = 0;
        model_led = 0;
    endtask

    initial model_clear();

    always @(posedge clk) begin
        if (rst) begin
            model_clear();
        end else begin
            int next_led;
            next_led = deb1 & deb2;
            hist1.push_back(int'(sw1));
            hist2.push_back(int'(sw2));
            if (window_flips(hist1, deb1)) deb1 = 1 - deb1;
            if (window_flips(hist2, deb2)) deb2 = 1 - deb2;
            while (hist1.size() > LIMIT + 4) void'(hist1.pop_front());
            while (hist2.size() > LIMIT + 4) void'(hist2.pop_front());
            model_led = next_led;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle();
        check_eq("led_vs_model", int'(led), model_led);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change only at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_sw(input logic s1, input logic s2);
        sw1 = s1;
        sw2 = s2;
    endtask

    // Counts edges until the LED reaches target; expired budget reports -1.
    task automatic measure(input string tag, input logic target, input int exp_edges);
        int n;
        bit found;
        n     = 0;
        found = 1'b0;
        while (n < 40 && !found) begin
            tick();
            n++;
            if (led === target) found = 1'b1;
        end
        check_eq(tag, found ? n : -1, exp_edges);
    endtask

    task automatic hold_expect_zero(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (led === 1'b1) seen = 1;
        end
        check_eq(tag, seen, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        set_sw(1'b1, 1'b1);

        // Reset held for three edges with both switches pressed.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("reset_hold", int'(led), 0);
        end
        rst = 1'b0;
        tick();
        check_eq("reset_release", int'(led), 0);

        // Truth table.
        set_sw(1'b0, 1'b0);
        hold(20);
        check_eq("tt_00", int'(led), 0);
        set_sw(1'b0, 1'b1);
        hold(20);
        check_eq("tt_01", int'(led), 0);
        set_sw(1'b1, 1'b0);
        hold(20);
        check_eq("tt_10", int'(led), 0);
        set_sw(1'b1, 1'b1);
        measure("tt_11_rise_edge", 1'b1, LAT);
        hold(20 - LAT);
        check_eq("tt_11", int'(led), 1);

        // Glitch rejection on switch 2.
        set_sw(1'b1, 1'b0);
        hold(20);
        set_sw(1'b1, 1'b1);
        hold(2);
        set_sw(1'b1, 1'b0);
        hold_expect_zero("glitch_reject", 12);
        set_sw(1'b1, 1'b1);
        measure("glitch_then_hold_rise", 1'b1, LAT);
        hold(5);

        // Bounce 1,0,1,0 then settle at 1.
        set_sw(1'b1, 1'b0);
        hold(20);
        for (int i = 0; i < 4; i++) begin
            sw2 = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        sw2 = 1'b1;
        measure("bounce_rise_edge", 1'b1, LAT);
        hold(5);

        // Release of switch 1 with switch 2 still pressed.
        set_sw(1'b0, 1'b1);
        measure("release_fall_edge", 1'b0, LAT);
        hold(10);
        check_eq("release_steady", int'(led), 0);

        // Mid-operation reset while both switches are rising.
        set_sw(1'b0, 1'b0);
        hold(20);
        set_sw(1'b1, 1'b1);
        hold(3);
        rst = 1'b1;
        tick();
        check_eq("mid_reset_led", int'(led), 0);
        rst = 1'b0;
        measure("mid_reset_restart_rise", 1'b1, LAT);
        hold(5);

        // Randomized activity with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            hold($urandom_range(1, 12));
        end
        set_sw(1'b1, 1'b1);
        hold(LAT + 2);
        check_eq("final_on", int'(led), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
